// File: rtl/if_id_prefetch_queue_pkg.sv
// Shared definitions for the IF/ID prefetch queue: entry layout, bubble word
// and default queue depth.
package if_id_prefetch_queue_pkg;

  localparam int IF_ID_ENTRY_W = 64;
  localparam logic [31:0] NOP_INSTR = 32'd0;
  localparam int DEFAULT_DEPTH = 4;

  // One queued fetch: PC+4 in the upper word, instruction in the lower word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_entry_t;

endpackage : if_id_prefetch_queue_pkg

// File: rtl/if_id_queue_ram.sv
// Storage for the prefetch queue: DEPTH x 64-bit register array with one
// write port and one asynchronous read port. Contents are never reset; the
// pointers and count in the parent decide what is valid.
module if_id_queue_ram
  import if_id_prefetch_queue_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [IF_ID_ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [IF_ID_ENTRY_W-1:0] rdata
);

  logic [IF_ID_ENTRY_W-1:0] mem [DEPTH];

  // Write the accepted fetch into its slot on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head entry is read combinationally so ID sees it the cycle it is valid.
  assign rdata = mem[raddr];

endmodule : if_id_queue_ram

// File: rtl/if_id_prefetch_queue.sv
// First-word-fall-through queue between IF and ID. Buffers {PC+4, instr}
// pairs so ID hazard stalls do not immediately freeze IF, and empties on a
// taken branch. Flush beats push/pop; a full queue rejects pushes even when
// a pop happens in the same cycle, since full is taken from registered state.
module if_id_prefetch_queue
  import if_id_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instruction_in,
  input  logic             pop_ready,
  input  logic             flush,
  output logic             freeze_if,
  output logic             pop_valid,
  output logic [31:0]      pc_out,
  output logic [31:0]      instruction_out,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         rd_ptr_reg;
  logic [PTR_W:0]           count_reg;
  logic                     full;
  logic                     empty;
  logic                     do_push;
  logic                     do_pop;
  if_id_entry_t             wr_entry;
  if_id_entry_t             rd_entry;
  logic [IF_ID_ENTRY_W-1:0] rd_data;

  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);

  // A flush discards the same-cycle push, so it must not reach the array.
  assign do_push = push_valid && !full && !flush;
  assign do_pop  = pop_ready && !empty && !flush;

  assign wr_entry = '{pc: pc_in, instr: instruction_in};

  if_id_queue_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr_reg),
    .wdata (wr_entry),
    .raddr (rd_ptr_reg),
    .rdata (rd_data)
  );

  // Pointer and occupancy update: flush first, then independent push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Present the head entry, or a zero NOP bubble while empty.
  always_comb begin
    rd_entry = if_id_entry_t'(rd_data);
    if (empty) begin
      pc_out          = 32'd0;
      instruction_out = NOP_INSTR;
    end else begin
      pc_out          = rd_entry.pc;
      instruction_out = rd_entry.instr;
    end
  end

  assign freeze_if = full;
  assign pop_valid = !empty;
  assign count     = count_reg;

endmodule : if_id_prefetch_queue

// File: tb/tb_if_id_prefetch_queue.sv
// Directed bench for the IF/ID prefetch queue: reset, fill, drain order,
// simultaneous push/pop with wrap, flush priority, full release and
// asynchronous mid-run reset.
module tb_if_id_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic        pop_ready;
  logic        flush;
  logic        freeze_if;
  logic        pop_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  if_id_prefetch_queue #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .push_valid      (push_valid),
    .pc_in           (pc_in),
    .instruction_in  (instruction_in),
    .pop_ready       (pop_ready),
    .flush           (flush),
    .freeze_if       (freeze_if),
    .pop_valid       (pop_valid),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic pr, input logic fl);
    push_valid     = pv;
    pc_in          = pc;
    instruction_in = ins;
    pop_ready      = pr;
    flush          = fl;
    @(posedge clk);
    #1;
    $display("txn t=%0t push=%0b pc_in=%0d pop=%0b flush=%0b -> count=%0d pop_valid=%0b pc_out=%0d instr=%h freeze=%0b",
             $time, pv, pc, pr, fl, count, pop_valid, pc_out, instruction_out, freeze_if);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    push_valid = 1'b0; pc_in = '0; instruction_in = '0; pop_ready = 1'b0; flush = 1'b0;
    #2;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid: got %0b expected 0", pop_valid); end
    checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL reset_freeze: got %0b expected 0", freeze_if); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc_out: got %h expected 0", pc_out); end
    checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction_out); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", count); end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), 32'hE3A00001 + 32'(i), 1'b0, 1'b0);
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      checks++; if (freeze_if !== (i == 3)) begin errors++; $display("FAIL fill_freeze[%0d]: got %0b expected %0b", i, freeze_if, (i == 3)); end
    end
    checks++; if (pc_out !== 32'd4) begin errors++; $display("FAIL fill_head_pc: got %0d expected 4", pc_out); end
    checks++; if (instruction_out !== 32'hE3A00001) begin errors++; $display("FAIL fill_head_instr: got %h expected e3a00001", instruction_out); end
    drive(1'b1, 32'd20, 32'hE3A00005, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_overflow_count: got %0d expected 4", count); end
    checks++; if (freeze_if !== 1'b1) begin errors++; $display("FAIL fill_overflow_freeze: got %0b expected 1", freeze_if); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pc_out !== 32'(4 * (i + 1))) begin errors++; $display("FAIL drain_pc[%0d]: got %0d expected %0d", i, pc_out, 4 * (i + 1)); end
      checks++; if (instruction_out !== 32'hE3A00001 + 32'(i)) begin errors++; $display("FAIL drain_instr[%0d]: got %h expected %h", i, instruction_out, 32'hE3A00001 + 32'(i)); end
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      checks++; if (count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 3 - i); end
    end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL drain_pop_valid: got %0b expected 0", pop_valid); end
    checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL drain_instr_nop: got %h expected 0", instruction_out); end
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL drain_pc_zero: got %h expected 0", pc_out); end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] seq [10];
    seq[0] = 32'd60; seq[1] = 32'd64;
    for (int k = 2; k < 10; k++) seq[k] = 32'd24 + 32'(4 * (k - 2));
    drive(1'b1, seq[0], seq[0] ^ 32'hA5000000, 1'b0, 1'b0);
    drive(1'b1, seq[1], seq[1] ^ 32'hA5000000, 1'b0, 1'b0);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_setup_count: got %0d expected 2", count); end
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq[i + 2], seq[i + 2] ^ 32'hA5000000, 1'b1, 1'b0);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
      checks++; if (pc_out !== seq[i + 1]) begin errors++; $display("FAIL b2b_head[%0d]: got %0d expected %0d", i, pc_out, seq[i + 1]); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (pc_out !== seq[8 + i]) begin errors++; $display("FAIL b2b_tail_pc[%0d]: got %0d expected %0d", i, pc_out, seq[8 + i]); end
      checks++; if (instruction_out !== (seq[8 + i] ^ 32'hA5000000)) begin errors++; $display("FAIL b2b_tail_instr[%0d]: got %h expected %h", i, instruction_out, seq[8 + i] ^ 32'hA5000000); end
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b expected 0", pop_valid); end
  endtask

  task automatic test_flush;
    drive(1'b1, 32'd70, 32'h11111111, 1'b0, 1'b0);
    drive(1'b1, 32'd74, 32'h22222222, 1'b0, 1'b0);
    drive(1'b1, 32'd78, 32'h33333333, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_setup_count: got %0d expected 3", count); end
    drive(1'b1, 32'd100, 32'h44444444, 1'b1, 1'b1);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL flush_pop_valid: got %0b expected 0", pop_valid); end
    drive(1'b1, 32'd200, 32'h55555555, 1'b0, 1'b0);
    checks++; if (pc_out !== 32'd200) begin errors++; $display("FAIL flush_target_pc: got %0d expected 200", pc_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_target_count: got %0d expected 1", count); end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_cleanup_count: got %0d expected 0", count); end
  endtask

  task automatic test_full_release;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'd80 + 32'(4 * i), 32'hB0000000 + 32'(i), 1'b0, 1'b0);
    checks++; if (freeze_if !== 1'b1) begin errors++; $display("FAIL release_setup_freeze: got %0b expected 1", freeze_if); end
    drive(1'b1, 32'd40, 32'hB0000040, 1'b1, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL release_count: got %0d expected 3", count); end
    checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL release_freeze: got %0b expected 0", freeze_if); end
    checks++; if (pc_out !== 32'd84) begin errors++; $display("FAIL release_head: got %0d expected 84", pc_out); end
    drive(1'b1, 32'd40, 32'hB0000040, 1'b0, 1'b0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL release_refill_count: got %0d expected 4", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (pc_out !== 32'd84 + 32'(4 * i)) begin errors++; $display("FAIL release_order[%0d]: got %0d expected %0d", i, pc_out, 84 + 4 * i); end
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    checks++; if (pc_out !== 32'd40) begin errors++; $display("FAIL release_last_pc: got %0d expected 40", pc_out); end
    checks++; if (instruction_out !== 32'hB0000040) begin errors++; $display("FAIL release_last_instr: got %h expected b0000040", instruction_out); end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'd300, 32'hC0000000, 1'b0, 1'b0);
    drive(1'b1, 32'd304, 32'hC0000001, 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_setup_count: got %0d expected 3", count); end
    push_valid = 1'b0; pop_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count: got %0d expected 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL areset_pop_valid: got %0b expected 0", pop_valid); end
    checks++; if (instruction_out !== 32'd0) begin errors++; $display("FAIL areset_instr: got %h expected 0", instruction_out); end
    checks++; if (freeze_if !== 1'b0) begin errors++; $display("FAIL areset_freeze: got %0b expected 0", freeze_if); end
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b1, 32'd400, 32'hD0000000, 1'b0, 1'b0);
    checks++; if (pc_out !== 32'd400) begin errors++; $display("FAIL areset_resume_pc: got %0d expected 400", pc_out); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL areset_resume_count: got %0d expected 1", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_full_release();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_if_id_prefetch_queue

// File: doc/if_id_prefetch_queue.md
Name: if_id_prefetch_queue

Overview:
- Decoupling buffer between the instruction-fetch stage and the decode stage of the 5-stage ARM pipeline.
- Captures each fetched {PC+4, Instruction} pair into a small FIFO and presents the oldest entry to ID, first-word-fall-through.
- Absorbs ID hazard stalls without immediately freezing IF.
- Drops all queued entries on a taken branch.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- PTR_W, 2, log2(DEPTH); pointer width. Count width is PTR_W+1.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- push_valid  input  1  IF has a valid fetched instruction this cycle.
- pc_in  input  32  PC+4 from the IF adder.
- instruction_in  input  32  word from instruction memory.
- pop_ready  input  1  ID consumes the head entry this cycle; 0 while the hazard unit stalls ID.
- flush  input  1  Branch_Tacken from EXE; discard all entries.
- freeze_if  output  1  to IF freeze; 1 when the queue is full.
- pop_valid  output  1  head entry valid (queue not empty).
- pc_out  output  32  head entry PC+4.
- instruction_out  output  32  head entry instruction.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64-bit array, 32-bit PC plus 32-bit instruction. Write pointer and read pointer are each PTR_W bits and wrap modulo DEPTH. A registered count tracks occupancy.
- Reset (rst=0, asynchronous):
  - Pointers and count go to 0; freeze_if=0; pop_valid=0.
  - pc_out and instruction_out read 0.
  - Array contents are not reset.
  - Reset asserted mid-operation discards everything immediately, without waiting for a clock edge.
- Derived signals, combinational from registered state:
  - full = (count==DEPTH); empty = (count==0).
  - freeze_if = full; pop_valid = !empty.
  - pc_out and instruction_out = array[rd_ptr] when !empty, else 32'd0. The zero word is the NOP bubble ID already treats as harmless.
- Accept rules, evaluated per rising edge in this priority order:
  1. flush=1: wr_ptr←0, rd_ptr←0, count←0. Any same-cycle push and pop are ignored. The IF stage loads the branch target that cycle; its fetch is pushed on the following cycle.
  2. do_push = push_valid && !full. Writes {pc_in, instruction_in} at wr_ptr, then wr_ptr++.
  3. do_pop = pop_ready && !empty. Advances rd_ptr.
  4. count update:
     - +1 when push only;
     - −1 when pop only;
     - unchanged when both or neither.
- Boundary cases:
  - Full with pop_ready=1: the pop is accepted. The push is rejected because full is registered state, and IF is frozen that cycle. Next cycle count=DEPTH−1 and freeze_if drops.
  - Empty with push: the entry becomes visible on pop_valid one cycle later. There is no same-cycle bypass, so latency from IF to ID is 1 cycle.
  - Empty with pop_ready=1: no effect; pointers hold.
  - Pointer wrap: DEPTH−1 → 0 with no special handling.
  - push_valid=1 while full: the data is dropped by design. IF holds the same PC because freeze_if=1, so the word is re-presented on the next cycle.

Decomposition:
- Shared package holds:
  - IF_ID_ENTRY_W = 64;
  - NOP_INSTR = 32'd0;
  - default DEPTH.
- One natural sub-module, if_id_queue_ram: DEPTH x 64 register array with one write port and one asynchronous read port, and no reset.
- Pointer, count and priority logic stay in the top module.

Test Plan:
- Reset: rst=0 mid-run with count=3 → count=0, pop_valid=0, instruction_out=0, freeze_if=0 immediately, before the next edge.
- Fill: pop_ready=0; push pc_in=4,8,12,16 with instruction_in=0xE3A00001..0xE3A00004 over 4 cycles → count=4 and freeze_if=1 after the 4th edge. A 5th push (pc=20) is dropped and count stays 4.
- Drain order: from full, pop_ready=1 and push_valid=0 → pc_out sequence 4,8,12,16 on consecutive cycles, then pop_valid=0 and instruction_out=0.
- Simultaneous push/pop at count=2: push pc=24 and pop in the same cycle → count stays 2, head advances. After 7 more push/pop cycles the pointers have wrapped, and FIFO order is preserved with PCs matching push order.
- Flush priority: count=3, assert flush with push_valid=1 (pc=100) and pop_ready=1 → count=0 and pop_valid=0 next cycle. A push of pc=200 on the following cycle appears at pc_out one cycle later.
- Full-release: at count=4, pop_ready=1 and push_valid=1 (pc=40) → pop accepted, push rejected, count=3, freeze_if=0. Next cycle's push of pc=40 is accepted, giving count=4.
